// File: rtl/add_path_pkg.sv
// Shared definitions for the add datapath sequencer: opcodes, FSM states,
// instruction field positions and the packed 25-bit instruction word.
// Latency: n/a (definitions only). Backpressure: n/a.
package add_path_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam int OPC_LSB  = 0;
  localparam int SRCA_LSB = 6;
  localparam int SRCB_LSB = 12;
  localparam int DST_LSB  = 18;
  localparam int INSTR_W  = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RD_A,
    S_RD_B,
    S_WRITE,
    S_FIN
  } state_e;

  // Member order matches the bit layout: dst [24:18], srcB [17:12],
  // srcA [11:6], opcode [5:0].
  typedef struct packed {
    logic [6:0] dst;
    logic [5:0] src_b;
    logic [5:0] src_a;
    logic [5:0] opcode;
  } instr_t;

endpackage

// File: rtl/add_path_alu.sv
// 64-bit adder/subtractor for the add datapath; sub_i=1 selects A-B.
// Latency: combinational. Backpressure: none.
// Ports: sub_i (opcode bit 0), a_i/b_i operands, res_o result modulo 2^64.
module add_path_alu
  import add_path_pkg::*;
(
  input  logic        sub_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] res_o
);

  assign res_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/add_path_seq.sv
// Sequencer owning the single-port RAM: fetch, read A, read B, write A+/-B.
// Latency: 4 cycles per ADD/SUB, 1 per illegal, HALT fetch + 1 FIN cycle.
// Backpressure: none; start is ignored unless idle.
// Ports: clk/rst (sync, active-high), start, mem_* RAM master port,
//        busy/done/illegal status, pc and instr_count observation.
module add_path_seq
  import add_path_pkg::*;
#(
  parameter logic [13:0] PROG_BASE = 14'd0,
  parameter logic [13:0] DATA_BASE = 14'd64,
  parameter logic [15:0] MAX_INSTR = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [13:0] mem_adr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [13:0] pc,
  output logic [15:0] instr_count
);

  state_e      state_q;
  instr_t      instr_q;
  logic [63:0] opa_q;
  logic [63:0] opb_q;
  logic [13:0] pc_q;
  logic [15:0] cnt_q;
  logic        illegal_q;

  instr_t      fetch_d;
  logic [13:0] pc_d;
  logic [15:0] cnt_d;
  logic        known_op_d;
  logic [63:0] alu_res;
  logic        unused_rdata_hi;

  assign fetch_d         = instr_t'(mem_rdata[INSTR_W-1:0]);
  assign unused_rdata_hi = ^mem_rdata[63:INSTR_W];
  assign pc_d            = pc_q + 14'd1;   // wraps 3FFF -> 0
  assign cnt_d           = cnt_q + 16'd1;
  assign known_op_d      = (fetch_d.opcode == OP_ADD) || (fetch_d.opcode == OP_SUB);

  add_path_alu u_alu (
    .sub_i (instr_q.opcode[0]),
    .a_i   (opa_q),
    .b_i   (opb_q),
    .res_o (alu_res)
  );

  // RAM port is decoded from state and latched fields only. The write enable
  // is also gated by rst so a WRITE cycle that coincides with reset never
  // lands in memory.
  always_comb begin
    mem_adr   = pc_q;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      S_RD_A:  mem_adr = DATA_BASE + {8'd0, instr_q.src_a};
      S_RD_B:  mem_adr = DATA_BASE + {8'd0, instr_q.src_b};
      S_WRITE: begin
        mem_adr   = DATA_BASE + {7'd0, instr_q.dst};
        mem_wdata = alu_res;
        mem_we    = !rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      pc_q      <= PROG_BASE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q      <= PROG_BASE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr_q <= fetch_d;
          if (fetch_d.opcode == OP_HALT) begin
            state_q <= S_FIN;
          end else if (!known_op_d) begin
            // Unknown opcode retires immediately and still consumes budget.
            illegal_q <= 1'b1;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            state_q   <= (cnt_d == MAX_INSTR) ? S_FIN : S_FETCH;
          end else begin
            state_q <= S_RD_A;
          end
        end
        S_RD_A: begin
          opa_q   <= mem_rdata;
          state_q <= S_RD_B;
        end
        S_RD_B: begin
          opb_q   <= mem_rdata;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          pc_q    <= pc_d;
          cnt_q   <= cnt_d;
          state_q <= (cnt_d == MAX_INSTR) ? S_FIN : S_FETCH;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign illegal     = illegal_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_add_path_seq.sv
// Bench for add_path_seq: directed scenarios plus randomized programs
// checked against an instruction-level model of the sequencer.
module tb_add_path_seq;

  localparam int TB_MAX = 3;
  localparam int DBASE  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] mem_adr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata;
  logic        busy, done, illegal;
  logic [13:0] pc;
  logic [15:0] instr_count;

  logic        tb_we, tb_clr;
  logic [13:0] tb_adr;
  logic [63:0] tb_dat;

  logic [63:0] ram [16384];
  logic [63:0] mdl [16384];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  add_path_seq #(.MAX_INSTR(16'(TB_MAX))) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .illegal(illegal), .pc(pc), .instr_count(instr_count)
  );

  assign mem_rdata = ram[mem_adr];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 16384; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_adr] <= mem_wdata;
      wr_cnt       <= wr_cnt + 1;
    end else if (tb_we) begin
      ram[tb_adr] <= tb_dat;
    end
  end

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [5:0] a,
                                      input logic [5:0] b, input logic [6:0] d);
    return {39'd0, d, b, a, op};
  endfunction

  task automatic clear_ram();
    @(negedge clk); tb_clr = 1'b1;
    @(negedge clk); tb_clr = 1'b0;
  endtask

  task automatic load(input int adr, input logic [63:0] dat);
    @(negedge clk); tb_we = 1'b1; tb_adr = 14'(adr); tb_dat = dat;
    @(negedge clk); tb_we = 1'b0;
  endtask

  // Pulses start and counts rising edges from the one that samples start
  // up to the one after which done is high; bounded at 200.
  task automatic run_dut(output int e);
    @(negedge clk); start = 1'b1;
    @(posedge clk); e = 1;
    @(negedge clk); start = 1'b0;
    while (done !== 1'b1 && e < 200) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
  endtask

  // Instruction-level model: executes the program held in mdl[].
  task automatic run_model(output int e_pc, output int e_cnt, output int e_ill,
                           output int e_wr, output int e_edges);
    int p, c;
    logic [63:0] w, va, vb;
    logic [5:0] op;
    p = 0; c = 0; e_ill = 0; e_wr = 0; e_edges = 1;
    for (int guard = 0; guard < 100000; guard++) begin
      w  = mdl[p];
      op = w[5:0];
      if (op == 6'h3F) begin e_edges += 1; break; end
      if (op == 6'h00 || op == 6'h01) begin
        va = mdl[DBASE + int'(w[11:6])];
        vb = mdl[DBASE + int'(w[17:12])];
        mdl[DBASE + int'(w[24:18])] = (op == 6'h01) ? va - vb : va + vb;
        e_wr++; e_edges += 4;
      end else begin
        e_ill = 1; e_edges += 1;
      end
      p = (p + 1) % 16384;
      c++;
      if (c == TB_MAX) break;
    end
    e_pc = p; e_cnt = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tb_we = 1'b0; tb_clr = 1'b0; tb_adr = '0; tb_dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    clear_ram();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b want 0", illegal); end
    checks++; if (pc !== 14'd0) begin errors++; $display("FAIL reset_pc got %0h want 0", pc); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", instr_count); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", mem_we); end
    checks++; if (mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", mem_wdata); end
  endtask

  task automatic test_add_halt();
    int e;
    clear_ram();
    load(0, enc(6'h00, 6'd0, 6'd1, 7'd2));
    load(1, enc(6'h3F, 6'd0, 6'd0, 7'd0));
    load(64, 64'd5);
    load(65, 64'd7);
    run_dut(e);
    // done is high in the 7th cycle counting the cycle start is asserted in
    checks++; if (e !== 6) begin errors++; $display("FAIL add_latency got %0d want 6", e); end
    checks++; if (ram[66] !== 64'd12) begin errors++; $display("FAIL add_result got %0h want c", ram[66]); end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL add_cnt got %0d want 1", instr_count); end
    checks++; if (pc !== 14'd1) begin errors++; $display("FAIL add_pc got %0h want 1", pc); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done_pulse got done=%0b busy=%0b want 0 0", done, busy); end
  endtask

  task automatic test_illegal();
    int e, w0;
    clear_ram();
    load(0, enc(6'h05, 6'd0, 6'd1, 7'd2));
    load(1, enc(6'h3F, 6'd0, 6'd0, 7'd0));
    w0 = wr_cnt;
    run_dut(e);
    checks++; if (e !== 3) begin errors++; $display("FAIL ill_latency got %0d want 3", e); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %0b want 1", illegal); end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL ill_cnt got %0d want 1", instr_count); end
    @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL ill_writes got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_sub();
    int e;
    clear_ram();
    load(0, enc(6'h01, 6'd0, 6'd1, 7'd2));
    load(1, enc(6'h3F, 6'd0, 6'd0, 7'd0));
    load(64, 64'd3);
    load(65, 64'd5);
    run_dut(e);
    checks++; if (ram[66] !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got %0h want fffffffffffffffe", ram[66]); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL sub_illegal got %0b want 0", illegal); end
  endtask

  task automatic test_alias();
    int e;
    clear_ram();
    load(0, enc(6'h00, 6'd2, 6'd2, 7'd2));
    load(1, enc(6'h3F, 6'd0, 6'd0, 7'd0));
    load(66, 64'd9);
    run_dut(e);
    checks++; if (ram[66] !== 64'd18) begin errors++; $display("FAIL alias_result got %0d want 18", ram[66]); end
  endtask

  task automatic test_budget();
    int e, w0;
    clear_ram();
    for (int k = 0; k < 5; k++) load(k, enc(6'h00, 6'd0, 6'd1, 7'(10 + k)));
    load(64, 64'd1);
    load(65, 64'd2);
    w0 = wr_cnt;
    run_dut(e);
    checks++; if (e !== 13) begin errors++; $display("FAIL budget_latency got %0d want 13", e); end
    checks++; if (pc !== 14'd3) begin errors++; $display("FAIL budget_pc got %0h want 3", pc); end
    checks++; if (instr_count !== 16'd3) begin errors++; $display("FAIL budget_cnt got %0d want 3", instr_count); end
    @(negedge clk);
    checks++; if (wr_cnt - w0 !== 3) begin errors++; $display("FAIL budget_writes got %0d want 3", wr_cnt - w0); end
    checks++; if (ram[77] !== 64'd0) begin errors++; $display("FAIL budget_overrun got %0h want 0", ram[77]); end
  endtask

  task automatic test_reset_write();
    int e, w0;
    clear_ram();
    load(0, enc(6'h00, 6'd0, 6'd1, 7'd2));
    load(1, enc(6'h3F, 6'd0, 6'd0, 7'd0));
    load(64, 64'd1);
    load(65, 64'd2);
    load(66, 64'hAA);
    w0 = wr_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstw_in_write got we=%0b want 1", mem_we); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstw_we_gated got %0b want 0", mem_we); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0 || pc !== 14'd0 || instr_count !== 16'd0) begin errors++; $display("FAIL rstw_idle got busy=%0b pc=%0h cnt=%0d want 0 0 0", busy, pc, instr_count); end
    checks++; if (ram[66] !== 64'hAA || wr_cnt != w0) begin errors++; $display("FAIL rstw_no_write got %0h writes=%0d want aa 0", ram[66], wr_cnt - w0); end
    run_dut(e);
    checks++; if (e !== 6 || ram[66] !== 64'd3) begin errors++; $display("FAIL rstw_rerun got e=%0d val=%0h want 6 3", e, ram[66]); end
  endtask

  task automatic test_random();
    int e, w0, n, sel, e_pc, e_cnt, e_ill, e_wr, e_edges, nbad;
    logic [5:0] op;
    for (int it = 0; it < 20; it++) begin
      clear_ram();
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 5);
        op  = (sel < 3) ? 6'h00 : (sel < 5) ? 6'h01 : 6'($urandom_range(2, 62));
        load(k, enc(op, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 7'($urandom_range(0, 7))));
      end
      if ($urandom_range(0, 3) != 0) load(n, enc(6'h3F, 6'd0, 6'd0, 7'd0));
      for (int a = 64; a < 72; a++) load(a, {$urandom, $urandom});
      @(negedge clk);
      for (int a = 0; a < 16384; a++) mdl[a] = ram[a];
      run_model(e_pc, e_cnt, e_ill, e_wr, e_edges);
      w0 = wr_cnt;
      run_dut(e);
      @(negedge clk);
      nbad = 0;
      for (int a = 0; a < 256; a++) if (ram[a] !== mdl[a]) nbad++;
      checks++; if (e !== e_edges) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", it, e, e_edges); end
      checks++; if (int'(pc) !== e_pc) begin errors++; $display("FAIL rnd%0d_pc got %0d want %0d", it, pc, e_pc); end
      checks++; if (int'(instr_count) !== e_cnt) begin errors++; $display("FAIL rnd%0d_cnt got %0d want %0d", it, instr_count, e_cnt); end
      checks++; if (int'(illegal) !== e_ill) begin errors++; $display("FAIL rnd%0d_illegal got %0d want %0d", it, illegal, e_ill); end
      checks++; if (wr_cnt - w0 !== e_wr) begin errors++; $display("FAIL rnd%0d_writes got %0d want %0d", it, wr_cnt - w0, e_wr); end
      checks++; if (nbad !== 0) begin errors++; $display("FAIL rnd%0d_mem got %0d bad words want 0", it, nbad); end
    end
  endtask

  initial begin
    test_reset();
    test_add_halt();
    test_illegal();
    test_sub();
    test_alias();
    test_budget();
    test_reset_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
